// File: rtl/mode_cycle_fsm_if.sv
// rtl/mode_cycle_fsm_if.sv - mode selection control/status bundle
//
// Purpose: groups the request inputs and the mode outputs of mode_cycle_fsm.
// Signals:
//   press_next   one-cycle pulse, advance one mode
//   press_prev   one-cycle pulse, go back one mode
//   hold_next    level, button held for auto-repeat advance
//   load_en      one-cycle strobe, load load_mode
//   load_mode    target mode for a load
//   mode         current mode (registered)
//   mode_changed one-cycle pulse, first cycle mode shows a new value
//   wrapped      one-cycle pulse, the last change wrapped around an end
// Modports: master drives requests and observes the mode; slave is the FSM.
interface mode_cycle_fsm_if #(
    parameter int MODE_W = 2
);
    logic              press_next;
    logic              press_prev;
    logic              hold_next;
    logic              load_en;
    logic [MODE_W-1:0] load_mode;
    logic [MODE_W-1:0] mode;
    logic              mode_changed;
    logic              wrapped;

    modport master (
        output press_next,
        output press_prev,
        output hold_next,
        output load_en,
        output load_mode,
        input  mode,
        input  mode_changed,
        input  wrapped
    );

    modport slave (
        input  press_next,
        input  press_prev,
        input  hold_next,
        input  load_en,
        input  load_mode,
        output mode,
        output mode_changed,
        output wrapped
    );
endinterface

// File: rtl/mode_cycle_fsm.sv
// rtl/mode_cycle_fsm.sv - N-mode press/hold/load mode selector with idle return
//
// Purpose: selects one of NUM_MODES display modes. Next/prev pulses step the
// mode, a held next button auto-repeats, a direct load jumps to a mode, and an
// idle timeout returns to HOME_MODE.
// Ports:
//   clk_100hz  system clock
//   rst        asynchronous, active-low reset
//   bus        mode_cycle_fsm_if slave: press_next, press_prev, hold_next,
//              load_en, load_mode in; mode, mode_changed, wrapped out
module mode_cycle_fsm #(
    parameter int NUM_MODES    = 4,
    parameter int HOME_MODE    = 0,
    parameter int WRAP         = 1,
    parameter int HOLD_TICKS   = 100,
    parameter int REPEAT_TICKS = 25,
    parameter int IDLE_TICKS   = 1000,
    parameter int MODE_W       = $clog2(NUM_MODES)
) (
    input  logic            clk_100hz,
    input  logic            rst,
    mode_cycle_fsm_if.slave bus
);

    localparam int RMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int RW   = (RMAX < 2) ? 1 : $clog2(RMAX);
    localparam int IW   = (IDLE_TICKS < 2) ? 1 : $clog2(IDLE_TICKS);

    localparam logic [RW-1:0]   HOLD_LAST = RW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0]   REP_LAST  = RW'(REPEAT_TICKS - 1);
    localparam logic [RW-1:0]   R_ONE     = RW'(1);
    localparam logic [IW-1:0]   IDLE_LAST = IW'((IDLE_TICKS == 0) ? 0 : IDLE_TICKS - 1);
    localparam logic [IW-1:0]   I_ONE     = IW'(1);
    // One extra bit so that stepping past the top of a non-power-of-two
    // range is detected before it can be truncated into a legal-looking value.
    localparam logic [MODE_W:0] LAST_X    = (MODE_W + 1)'(NUM_MODES - 1);
    localparam logic [MODE_W:0] HOME_X    = (MODE_W + 1)'(HOME_MODE);
    localparam logic [MODE_W:0] ONE_X     = (MODE_W + 1)'(1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RUN
    } rep_state_t;

    rep_state_t      r_state;
    logic [RW-1:0]   cnt_r;
    logic [IW-1:0]   cnt_i;

    logic            rep_adv;
    logic            load_ok;
    logic            fwd;
    logic            bwd;
    logic            any_event;
    logic            timeout;
    logic [MODE_W:0] mode_x;
    logic [MODE_W:0] nxt_x;
    logic            nxt_wrap;

    always_comb begin
        mode_x    = {1'b0, bus.mode};
        rep_adv   = 1'b0;
        if (bus.hold_next) begin
            if (r_state == R_WAIT && cnt_r == HOLD_LAST) begin
                rep_adv = 1'b1;
            end
            if (r_state == R_RUN && cnt_r == REP_LAST) begin
                rep_adv = 1'b1;
            end
        end

        // An out-of-range load is dropped entirely, letting steps through.
        load_ok   = bus.load_en && ({1'b0, bus.load_mode} <= LAST_X);
        fwd       = bus.press_next || rep_adv;
        bwd       = bus.press_prev;
        any_event = load_ok || fwd || bwd;
        timeout   = (IDLE_TICKS != 0) && !any_event && (mode_x != HOME_X)
                    && (cnt_i == IDLE_LAST);

        nxt_x     = mode_x;
        nxt_wrap  = 1'b0;
        if (load_ok) begin
            nxt_x = {1'b0, bus.load_mode};
        end else if (fwd && !bwd) begin
            if (mode_x == LAST_X) begin
                if (WRAP != 0) begin
                    nxt_x    = '0;
                    nxt_wrap = 1'b1;
                end
            end else begin
                nxt_x = mode_x + ONE_X;
            end
        end else if (bwd && !fwd) begin
            if (mode_x == '0) begin
                if (WRAP != 0) begin
                    nxt_x    = LAST_X;
                    nxt_wrap = 1'b1;
                end
            end else begin
                nxt_x = mode_x - ONE_X;
            end
        end else if (timeout) begin
            nxt_x = HOME_X;
        end
    end

    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            r_state          <= R_IDLE;
            cnt_r            <= '0;
            cnt_i            <= '0;
            bus.mode         <= HOME_X[MODE_W-1:0];
            bus.mode_changed <= 1'b0;
            bus.wrapped      <= 1'b0;
        end else begin
            if (!bus.hold_next) begin
                r_state <= R_IDLE;
                cnt_r   <= '0;
            end else begin
                case (r_state)
                    R_IDLE: begin
                        r_state <= R_WAIT;
                        cnt_r   <= '0;
                    end
                    R_WAIT: begin
                        if (cnt_r == HOLD_LAST) begin
                            r_state <= R_RUN;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_r + R_ONE;
                        end
                    end
                    R_RUN: begin
                        if (cnt_r == REP_LAST) begin
                            cnt_r <= '0;
                        end else begin
                            cnt_r <= cnt_r + R_ONE;
                        end
                    end
                    default: begin
                        r_state <= R_IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end

            bus.mode         <= nxt_x[MODE_W-1:0];
            bus.mode_changed <= (nxt_x != mode_x);
            bus.wrapped      <= nxt_wrap;

            // Blocked and cancelled steps still count as activity; a held
            // button only counts through the advances it produces.
            if (any_event || timeout || mode_x == HOME_X || IDLE_TICKS == 0) begin
                cnt_i <= '0;
            end else begin
                cnt_i <= cnt_i + I_ONE;
            end
        end
    end

endmodule
